// File: rtl/sae_pkg.sv
// Shared types for the SAE stream cipher: transaction modes, error codes,
// key-state encoding and the per-entry tag carried through the output FIFO.
package sae_pkg;

   typedef enum logic [1:0] {
      MODE_NOP     = 2'b00,
      MODE_KEYGEN  = 2'b01,
      MODE_ENCRYPT = 2'b10,
      MODE_DECRYPT = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ERR_OK     = 2'b00,
      ERR_RANGE  = 2'b01,
      ERR_NOKEY  = 2'b10,
      ERR_BADKEY = 2'b11
   } err_e;

   typedef enum logic {
      KEY_NONE  = 1'b0,
      KEY_KEYED = 1'b1
   } key_state_e;

   // Data width is a module parameter, so the package only fixes the tag;
   // the top level prepends the data field to form the full FIFO entry.
   typedef struct packed {
      err_e  err;
      mode_e mode;
   } sae_tag_t;

endpackage

// File: rtl/sae_sync_fifo.sv
// Show-ahead single-clock FIFO; the head is always on rdata, and when empty
// rdata holds the most recently popped entry.
module sae_sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_last;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty  = (r_wr_ptr == r_rd_ptr);
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign rdata  = empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_last   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/sae_stream_cipher.sv
// Streaming SAE engine: key generation, modular-add encrypt/decrypt and a
// tagged output FIFO with a saturating count of error entries.
module sae_stream_cipher
   import sae_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int MOD    = 128,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_err,
   output logic [1:0]        out_mode,
   output logic              key_valid,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam logic [DATA_W:0] MOD_W = (DATA_W+1)'(MOD);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      sae_tag_t          tag;
   } entry_t;

   key_state_e        r_state;
   key_state_e        w_state_nxt;
   logic [DATA_W-1:0] r_priv;
   logic [DATA_W-1:0] r_pub;
   logic [CNT_W-1:0]  r_err_cnt;
   mode_e             w_mode;
   logic              w_in_range;
   logic              w_keygen_ok;
   logic              w_accept;
   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W:0]   w_pub_full;
   entry_t            w_entry;
   entry_t            w_head;

   // Operands are both below MOD, so one conditional subtract is a full reduction.
   function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= MOD_W) sum = sum - MOD_W;
      return sum[DATA_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_mode     = mode_e'(in_mode);
   assign w_in_range = ({1'b0, in_data} < MOD_W);
   assign w_pub_full = MOD_W - {1'b0, in_data};
   assign w_accept   = in_valid & ~w_full;
   assign w_push     = w_accept & (w_mode != MODE_NOP);

   always_comb begin
      w_entry.data     = '0;
      w_entry.tag.err  = ERR_OK;
      w_entry.tag.mode = w_mode;
      w_keygen_ok      = 1'b0;
      case (w_mode)
         MODE_KEYGEN: begin
            if ((in_data != '0) && w_in_range) begin
               w_entry.data = w_pub_full[DATA_W-1:0];
               w_keygen_ok  = 1'b1;
            end else begin
               w_entry.tag.err = ERR_BADKEY;
            end
         end
         MODE_ENCRYPT, MODE_DECRYPT: begin
            if (r_state != KEY_KEYED)  w_entry.tag.err = ERR_NOKEY;
            else if (!w_in_range)      w_entry.tag.err = ERR_RANGE;
            else w_entry.data = mod_add(in_data, (w_mode == MODE_ENCRYPT) ? r_pub : r_priv);
         end
         default: ;
      endcase
   end

   // Once keyed, only reset leaves KEYED; a re-key just reloads the pair.
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept && w_keygen_ok) w_state_nxt = KEY_KEYED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= KEY_NONE;
         r_priv    <= '0;
         r_pub     <= '0;
         r_err_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept && w_keygen_ok) begin
            r_priv <= in_data;
            r_pub  <= w_pub_full[DATA_W-1:0];
         end
         if (w_push && (w_entry.tag.err != ERR_OK)) r_err_cnt <= sat_inc(r_err_cnt);
      end
   end

   sae_sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .wdata (w_entry),
      .pop   (out_ready & ~w_empty),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign in_ready  = ~w_full;
   assign out_valid = ~w_empty;
   assign out_data  = w_head.data;
   assign out_err   = w_head.tag.err;
   assign out_mode  = w_head.tag.mode;
   assign key_valid = (r_state == KEY_KEYED);
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_sae_stream_cipher.sv
// Scoreboard bench for sae_stream_cipher (DATA_W=8, MOD=128, DEPTH=4, CNT_W=8).
module tb_sae_stream_cipher;

   localparam logic [1:0] M_NOP = 2'b00, M_KEY = 2'b01, M_ENC = 2'b10, M_DEC = 2'b11;
   localparam logic [1:0] E_OK = 2'b00, E_RANGE = 2'b01, E_NOKEY = 2'b10, E_BADKEY = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_mode = 2'b00;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [1:0] out_err;
   logic [1:0] out_mode;
   logic       key_valid;
   logic [7:0] err_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_pops = 0;

   logic [11:0] q[$];
   logic [7:0]  m_priv = 8'h00;
   logic [7:0]  m_pub = 8'h00;
   bit          m_keyed = 1'b0;
   int          m_err = 0;

   sae_stream_cipher #(.DATA_W(8), .MOD(128), .DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .out_mode(out_mode), .key_valid(key_valid), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
      $fatal(1);
   end

   // Expected {data, err, mode} written straight from the SAE rules, using % for reduction.
   function automatic logic [11:0] model(input logic [1:0] m, input logic [7:0] d);
      logic [7:0] r;
      logic [1:0] e;
      int s;
      r = 8'h00;
      e = E_OK;
      if (m == M_KEY) begin
         if (d >= 1 && d < 128) r = 8'(128 - int'(d));
         else e = E_BADKEY;
      end else if (m == M_ENC || m == M_DEC) begin
         if (!m_keyed) e = E_NOKEY;
         else if (d >= 128) e = E_RANGE;
         else begin
            s = (int'(d) + int'((m == M_ENC) ? m_pub : m_priv)) % 128;
            r = 8'(s);
         end
      end
      return {r, e, m};
   endfunction

   // Scoreboard: the head is popped on the next rising edge when valid and ready.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got %h/%h/%h, required no output", out_data, out_err, out_mode);
         end else begin
            logic [11:0] exp;
            exp = q.pop_front();
            n_pops++;
            if ({out_data, out_err, out_mode} !== exp) begin
               failures++;
               $display("FAIL sb_entry: got data=%h err=%h mode=%h, required data=%h err=%h mode=%h",
                        out_data, out_err, out_mode, exp[11:4], exp[3:2], exp[1:0]);
            end
         end
      end
   end

   task automatic send(input logic [1:0] m, input logic [7:0] d);
      logic [11:0] e;
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_mode = m; in_data = d;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL send_accept: in_ready=0 for 64 cycles (mode=%h data=%h), required 1", m, d);
      end else begin
         e = model(m, d);
         if (m != M_NOP) q.push_back(e);
         if (m == M_KEY && d >= 1 && d < 128) begin
            m_priv = d; m_pub = 8'(128 - int'(d)); m_keyed = 1'b1;
         end
         if (m != M_NOP && e[3:2] != E_OK && m_err < 255) m_err++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (q.size() == 0) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_drain: %0d entries never came out, required 0", name, q.size());
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_empty: out_valid=%b, required 0", name, out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, key_valid, err_cnt, out_data, out_err, out_mode} !== {1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00}) begin
         failures++;
         $display("FAIL reset_state: out_valid=%b in_ready=%b key_valid=%b err_cnt=%h out=%h/%h/%h, required 0 1 0 00 00/0/0",
                  out_valid, in_ready, key_valid, err_cnt, out_data, out_err, out_mode);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_nokey();
      out_ready = 1'b1;
      send(M_ENC, 8'h61);
      wait_empty("nokey");
      checks++;
      if (err_cnt !== 8'd1 || key_valid !== 1'b0) begin
         failures++;
         $display("FAIL nokey_status: err_cnt=%0d key_valid=%b, required 1 0", err_cnt, key_valid);
      end
   endtask

   task automatic test_keygen_encdec();
      send(M_KEY, 8'h38);
      checks++;
      if (key_valid !== 1'b1) begin
         failures++;
         $display("FAIL keygen_valid: key_valid=%b, required 1", key_valid);
      end
      send(M_ENC, 8'h61);
      send(M_DEC, 8'h29);
      wait_empty("encdec");
      checks++;
      if (err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL encdec_errcnt: err_cnt=%0d, required 1", err_cnt);
      end
   endtask

   task automatic test_bad_key_range();
      send(M_KEY, 8'h00);
      send(M_KEY, 8'h80);
      send(M_ENC, 8'h80);
      send(M_NOP, 8'h55);
      send(M_ENC, 8'h61);
      wait_empty("badkey");
      checks++;
      if (err_cnt !== 8'd4 || key_valid !== 1'b1) begin
         failures++;
         $display("FAIL badkey_status: err_cnt=%0d key_valid=%b, required 4 1", err_cnt, key_valid);
      end
   endtask

   task automatic test_full();
      int pops0;
      pops0 = n_pops;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(M_ENC, 8'(8'h10 + i));
      fork
         send(M_ENC, 8'h14);
         begin
            repeat (3) begin
               @(negedge clk);
               checks++;
               if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                  failures++;
                  $display("FAIL full_hold: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
               end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL full_pop_cycle: in_ready=%b, required 0", in_ready);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL full_after_pop: in_ready=%b, required 1", in_ready);
            end
         end
      join
      out_ready = 1'b1;
      wait_empty("full");
      checks++;
      if (n_pops - pops0 !== 5) begin
         failures++;
         $display("FAIL full_count: popped %0d, required 5", n_pops - pops0);
      end
   endtask

   task automatic test_back_to_back();
      int c0, pops0;
      out_ready = 1'b1;
      c0 = cyc;
      pops0 = n_pops;
      for (int x = 0; x < 128; x++) begin
         send(M_ENC, 8'(x));
         send(M_DEC, 8'((x + int'(m_pub)) % 128));
      end
      checks++;
      if (cyc - c0 !== 256) begin
         failures++;
         $display("FAIL stream_rate: 256 transactions took %0d cycles, required 256", cyc - c0);
      end
      wait_empty("stream");
      checks++;
      if (n_pops - pops0 !== 256) begin
         failures++;
         $display("FAIL stream_count: popped %0d, required 256", n_pops - pops0);
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      send(M_ENC, 8'h01);
      send(M_DEC, 8'h02);
      send(M_KEY, 8'h05);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || err_cnt !== 8'h00 || key_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: out_valid=%b err_cnt=%h key_valid=%b, required 0 00 0",
                  out_valid, err_cnt, key_valid);
      end
      q.delete();
      m_keyed = 1'b0; m_priv = 8'h00; m_pub = 8'h00; m_err = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_discard: out_valid=%b, required 0", out_valid);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(M_DEC, 8'h10);
      wait_empty("rekey");
   endtask

   task automatic test_err_saturate();
      out_ready = 1'b1;
      for (int i = 0; i < 260; i++) send(M_ENC, 8'(i));
      wait_empty("sat");
      checks++;
      if (err_cnt !== 8'hFF) begin
         failures++;
         $display("FAIL err_saturate: err_cnt=%h, required ff", err_cnt);
      end
      checks++;
      if (err_cnt !== 8'(m_err)) begin
         failures++;
         $display("FAIL err_model: err_cnt=%0d, required %0d", err_cnt, m_err);
      end
   endtask

   initial begin
      test_reset();
      test_nokey();
      test_keygen_encdec();
      test_bad_key_range();
      test_full();
      test_back_to_back();
      test_reset_midstream();
      test_err_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
